// File: rtl/pe_mcxmac_pkg.sv
// Shared types and constants for the MAC transmit pause scheduler.
package pe_mcxmac_pkg;

  localparam int unsigned QW_DEF       = 16;
  localparam int unsigned SLOT_CYC_DEF = 64;

  localparam logic [15:0] XON_QUANTA = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLIENT = 2'd1,
    ST_CTRL   = 2'd2
  } sched_state_e;

endpackage

// File: rtl/pe_mcxmac_pause_sched_if.sv
// Frame handshake between the scheduler, the client/control-frame sources and the TX function block.
import pe_mcxmac_pkg::*;

interface pe_mcxmac_pause_sched_if #(
  parameter int unsigned QW = QW_DEF
);
  logic          cli_tx_req;
  logic          cli_tx_gnt;
  logic          ctl_tx_req;
  logic [QW-1:0] ctl_tx_quanta;
  logic          tx_frame_done;

  modport master (
    output cli_tx_req, tx_frame_done,
    input  cli_tx_gnt, ctl_tx_req, ctl_tx_quanta
  );

  modport slave (
    input  cli_tx_req, tx_frame_done,
    output cli_tx_gnt, ctl_tx_req, ctl_tx_quanta
  );
endinterface

// File: rtl/pe_mcxmac_quanta_timer.sv
// Pause-quantum down-counter: a SLOT_CYC prescaler drives a loadable counter that saturates at 0.
module pe_mcxmac_quanta_timer
  import pe_mcxmac_pkg::*;
#(
  parameter int unsigned QW       = QW_DEF,
  parameter int unsigned SLOT_CYC = SLOT_CYC_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_clr,
  input  logic [QW-1:0] i_load_val,
  output logic          o_nz,
  output logic          o_expire_c
);
  localparam int unsigned PW = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;

  logic [PW-1:0] r_pre, w_pre_nxt;
  logic [QW-1:0] r_cnt, w_cnt_nxt;
  logic          r_nz;
  logic          w_wrap;

  assign w_wrap = (r_pre == PW'(SLOT_CYC - 1));

  // Prescaler only runs while the counter is non-zero; a load restarts the quantum.
  always_comb begin
    w_pre_nxt = '0;
    w_cnt_nxt = r_cnt;
    if (i_load) begin
      w_cnt_nxt = i_load_val;
    end else if (i_clr) begin
      w_cnt_nxt = '0;
    end else if (r_cnt != '0) begin
      w_pre_nxt = w_wrap ? '0 : r_pre + PW'(1);
      if (w_wrap) w_cnt_nxt = r_cnt - QW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
      r_cnt <= '0;
      r_nz  <= 1'b0;
    end else begin
      r_pre <= w_pre_nxt;
      r_cnt <= w_cnt_nxt;
      r_nz  <= (w_cnt_nxt != '0);
    end
  end

  assign o_nz       = r_nz;
  assign o_expire_c = w_wrap && (r_cnt == QW'(1)) && !i_load && !i_clr;

endmodule

// File: rtl/pe_mcxmac_pause_sched.sv
// TX scheduler arbitrating client and PAUSE frames, honouring received PAUSE and issuing XOFF/XON.
// Optional PE_MCXMAC_PAUSE_STATS_EN adds saturating PAUSE tx/rx frame counters.
module pe_mcxmac_pause_sched
  import pe_mcxmac_pkg::*;
#(
  parameter int unsigned QW       = QW_DEF,
  parameter int unsigned SLOT_CYC = SLOT_CYC_DEF
) (
  input  logic          tx_clk,
  input  logic          tx_rst,
  input  logic          cfg_tx_flow_en,
  input  logic          cfg_rx_flow_en,
  input  logic [QW-1:0] cfg_pause_quanta,
  input  logic [QW-1:0] cfg_refresh_q,
  input  logic          xoff_req,
  input  logic          rx_pause_vld,
  input  logic [QW-1:0] rx_pause_quanta,
  output logic          tx_paused,
`ifdef PE_MCXMAC_PAUSE_STATS_EN
  output logic [15:0]   stat_pause_tx,
  output logic [15:0]   stat_pause_rx,
`endif
  pe_mcxmac_pause_sched_if.slave tx_if
);
  sched_state_e  r_state, w_state_nxt;
  logic          r_gnt, w_gnt_nxt;
  logic          r_ctl_req, w_ctl_req_nxt;
  logic [QW-1:0] r_ctl_q, w_ctl_q_nxt;
  logic          r_pend, r_xoff_d, r_xoff_sent;
  logic [QW-1:0] r_pend_q;

  logic w_paused, w_rx_load, w_rx_clr;
  logic w_ref_load, w_ref_clr, w_ref_exp;
  logic w_unused_rx_exp, w_unused_ref_nz;
  logic w_take_ctl, w_take_cli, w_done_ctl;
  logic w_xoff_rise, w_xon, w_refresh;

  assign w_take_ctl  = (r_state == ST_IDLE) && r_pend && cfg_tx_flow_en;
  assign w_take_cli  = (r_state == ST_IDLE) && !w_take_ctl && tx_if.cli_tx_req && !w_paused;
  assign w_done_ctl  = (r_state == ST_CTRL) && tx_if.tx_frame_done;
  assign w_xoff_rise = cfg_tx_flow_en && xoff_req && !r_xoff_d;
  assign w_xon       = cfg_tx_flow_en && !xoff_req && r_xoff_d && r_xoff_sent;
  assign w_refresh   = cfg_tx_flow_en && xoff_req && w_ref_exp;

  assign w_rx_load  = rx_pause_vld && cfg_rx_flow_en;
  assign w_rx_clr   = !cfg_rx_flow_en;
  // Refresh interval starts when an XOFF frame finishes while the FIFO is still above high water.
  assign w_ref_load = w_done_ctl && (r_ctl_q != QW'(XON_QUANTA)) && xoff_req && cfg_tx_flow_en;
  assign w_ref_clr  = !xoff_req || !cfg_tx_flow_en;

  pe_mcxmac_quanta_timer #(.QW(QW), .SLOT_CYC(SLOT_CYC)) u_rx_timer (
    .clk        (tx_clk),
    .rst        (tx_rst),
    .i_load     (w_rx_load),
    .i_clr      (w_rx_clr),
    .i_load_val (rx_pause_quanta),
    .o_nz       (w_paused),
    .o_expire_c (w_unused_rx_exp)
  );

  pe_mcxmac_quanta_timer #(.QW(QW), .SLOT_CYC(SLOT_CYC)) u_ref_timer (
    .clk        (tx_clk),
    .rst        (tx_rst),
    .i_load     (w_ref_load),
    .i_clr      (w_ref_clr),
    .i_load_val (cfg_refresh_q),
    .o_nz       (w_unused_ref_nz),
    .o_expire_c (w_ref_exp)
  );

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      r_state   <= ST_IDLE;
      r_gnt     <= 1'b0;
      r_ctl_req <= 1'b0;
      r_ctl_q   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_ctl_req <= w_ctl_req_nxt;
      r_ctl_q   <= w_ctl_q_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_take_ctl)      w_state_nxt = ST_CTRL;
        else if (w_take_cli) w_state_nxt = ST_CLIENT;
      end
      ST_CLIENT, ST_CTRL: begin
        if (tx_if.tx_frame_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_gnt_nxt     = 1'b0;
    w_ctl_req_nxt = r_ctl_req;
    w_ctl_q_nxt   = r_ctl_q;
    if (w_take_ctl) begin
      w_ctl_req_nxt = 1'b1;
      w_ctl_q_nxt   = r_pend_q;
    end else if (w_take_cli) begin
      w_gnt_nxt = 1'b1;
    end
    if (w_done_ctl) w_ctl_req_nxt = 1'b0;
  end

  // Single pending-control slot; the latest XOFF/XON/refresh event overwrites its quanta.
  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      r_pend      <= 1'b0;
      r_pend_q    <= '0;
      r_xoff_d    <= 1'b0;
      r_xoff_sent <= 1'b0;
    end else begin
      r_xoff_d <= xoff_req;
      if (!cfg_tx_flow_en) begin
        r_pend      <= 1'b0;
        r_xoff_sent <= 1'b0;
      end else begin
        if (w_xoff_rise || w_refresh) begin
          r_pend   <= 1'b1;
          r_pend_q <= cfg_pause_quanta;
        end else if (w_xon) begin
          r_pend   <= 1'b1;
          r_pend_q <= QW'(XON_QUANTA);
        end else if (w_take_ctl) begin
          r_pend <= 1'b0;
        end
        if (w_xoff_rise)  r_xoff_sent <= 1'b1;
        else if (w_xon)   r_xoff_sent <= 1'b0;
      end
    end
  end

  assign tx_if.cli_tx_gnt    = r_gnt;
  assign tx_if.ctl_tx_req    = r_ctl_req;
  assign tx_if.ctl_tx_quanta = r_ctl_q;
  assign tx_paused           = w_paused;

`ifdef PE_MCXMAC_PAUSE_STATS_EN
  logic [15:0] r_stat_tx, r_stat_rx;

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      r_stat_tx <= '0;
      r_stat_rx <= '0;
    end else begin
      if (w_done_ctl && (r_stat_tx != 16'hFFFF)) r_stat_tx <= r_stat_tx + 16'd1;
      if (w_rx_load && (r_stat_rx != 16'hFFFF))  r_stat_rx <= r_stat_rx + 16'd1;
    end
  end

  assign stat_pause_tx = r_stat_tx;
  assign stat_pause_rx = r_stat_rx;
`endif

endmodule
